// File: rtl/stream_supervisor_pkg.sv
// Shared types and constants for the stream supervisor: FSM state codes,
// active-low LED patterns and the saturating error-counter helper.
package stream_supervisor_pkg;

  typedef enum logic [2:0] {
    StResetHold  = 3'd0,
    StWaitFrames = 3'd1,
    StPrefill    = 3'd2,
    StStream     = 3'd3
  } state_e;

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] CntMax = '1;

  // LED patterns ordered {red, green, blue}; a 0 lights the LED
  localparam logic [2:0] LedReset     = 3'b011;
  localparam logic [2:0] LedWait      = 3'b110;
  localparam logic [2:0] LedPrefill   = 3'b100;
  localparam logic [2:0] LedStream    = 3'b101;
  localparam logic [2:0] LedStreamErr = 3'b001;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == CntMax) ? v : v + CntW'(1);
  endfunction

endpackage

// File: rtl/stream_supervisor_if.sv
// FIFO-side control bundle: occupancy/flags towards the supervisor,
// datapath reset and read/write enables back towards the FIFO.
interface stream_supervisor_if #(
    parameter int unsigned LEVEL_W = 5
) ();

    logic [LEVEL_W-1:0] fifo_level;
    logic               fifo_full;
    logic               fifo_empty;
    logic               sys_rst;
    logic               write_en;
    logic               read_en;

    modport master (
        input  fifo_level, fifo_full, fifo_empty,
        output sys_rst, write_en, read_en
    );

    modport slave (
        output fifo_level, fifo_full, fifo_empty,
        input  sys_rst, write_en, read_en
    );

endinterface

// File: rtl/stream_supervisor_sw_debounce.sv
// Synchronises the raw active-low user switch and accepts a level change only
// after DEBOUNCE_CYCLES identical samples; press_o pulses on the accepted 1->0 change.
module stream_supervisor_sw_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned StableW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [StableW-1:0] StableLast = StableW'(DEBOUNCE_CYCLES - 1);

    logic               sw_s1_q, sw_s2_q;
    logic               level_q, level_d;
    logic               press_q, press_d;
    logic [StableW-1:0] cnt_q, cnt_d;

    // Counter tracks consecutive samples that disagree with the accepted level
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sw_s2_q != level_q) begin
            if (cnt_q == StableLast) begin
                level_d = sw_s2_q;
                press_d = ~sw_s2_q;
            end else begin
                cnt_d = cnt_q + StableW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1_q <= 1'b1;
            sw_s2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sw_s1_q <= sw_i;
            sw_s2_q <= sw_s1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/stream_supervisor.sv
// Sequences datapath reset, frame settling, FIFO prefill and streaming; gates the
// FIFO enables, watches for frame-clock loss and counts underruns/overruns.
module stream_supervisor
    import stream_supervisor_pkg::*;
#(
    parameter int unsigned SETTLE_FRAMES   = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1024,
    parameter int unsigned FCLK_TIMEOUT    = 4096,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned PREFILL_LEVEL   = 8,
    parameter int unsigned LEVEL_W         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_lock,
    input  logic                  user_sw,
    input  logic                  fclk,
    stream_supervisor_if.master   fifo_if,
    output logic                  led_red,
    output logic                  led_green,
    output logic                  led_blue,
    output logic [2:0]            state_o,
    output logic [CntW-1:0]       underrun_cnt,
    output logic [CntW-1:0]       overrun_cnt
);

    localparam int unsigned EdgeW = $clog2(SETTLE_FRAMES + 1);
    localparam int unsigned ToW   = $clog2(FCLK_TIMEOUT + 1);
    localparam logic [EdgeW-1:0]   EdgeLast   = EdgeW'(SETTLE_FRAMES - 1);
    localparam logic [ToW-1:0]     ToLast     = ToW'(FCLK_TIMEOUT - 1);
    localparam logic [LEVEL_W-1:0] PrefillLvl = LEVEL_W'(PREFILL_LEVEL);

    logic               lock_s1_q, lock_s2_q;
    logic               fclk_s1_q, fclk_s2_q, fclk_s3_q;
    logic               fclk_fall, fclk_edge;
    logic               sw_level, sw_press;
    state_e             state_q, state_d;
    logic               sys_rst_q;
    logic [EdgeW-1:0]   edge_q, edge_d;
    logic [ToW-1:0]     timeout_q, timeout_d;
    logic [CntW-1:0]    under_q, under_d, over_q, over_d;
    logic [LEVEL_W-1:0] level;
    logic [2:0]         led;

    assign level     = fifo_if.fifo_level;
    assign fclk_fall = fclk_s3_q & ~fclk_s2_q;
    assign fclk_edge = fclk_s3_q ^ fclk_s2_q;

    stream_supervisor_sw_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk    (clk),
        .rst    (rst),
        .sw_i   (user_sw),
        .level_o(sw_level),
        .press_o(sw_press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_s1_q <= 1'b0;
            lock_s2_q <= 1'b0;
            fclk_s1_q <= 1'b0;
            fclk_s2_q <= 1'b0;
            fclk_s3_q <= 1'b0;
        end else begin
            lock_s1_q <= pll_lock;
            lock_s2_q <= lock_s1_q;
            fclk_s1_q <= fclk;
            fclk_s2_q <= fclk_s1_q;
            fclk_s3_q <= fclk_s2_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        under_d   = under_q;
        over_d    = over_q;
        edge_d    = '0;
        timeout_d = '0;

        if (state_q == StWaitFrames) begin
            edge_d = fclk_fall ? edge_q + EdgeW'(1) : edge_q;
        end
        if (state_q != StResetHold && !fclk_edge) begin
            timeout_d = (timeout_q == ToLast) ? timeout_q : timeout_q + ToW'(1);
        end

        // Lock loss outranks the switch, which outranks frame-clock loss
        if (!lock_s2_q) begin
            state_d = StResetHold;
        end else if (sw_press) begin
            state_d = StResetHold;
            under_d = '0;
            over_d  = '0;
        end else if (state_q != StResetHold && timeout_q == ToLast) begin
            state_d = StResetHold;
        end else begin
            case (state_q)
                StResetHold:  if (sw_level) state_d = StWaitFrames;
                StWaitFrames: if (fclk_fall && edge_q == EdgeLast) state_d = StPrefill;
                StPrefill:    if (level >= PrefillLvl) state_d = StStream;
                StStream: begin
                    if (fclk_fall) begin
                        if (fifo_if.fifo_empty) begin
                            under_d = sat_inc(under_q);
                            state_d = StPrefill;
                        end else if (fifo_if.fifo_full) begin
                            over_d = sat_inc(over_q);
                        end
                    end
                end
                default: state_d = StResetHold;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StResetHold;
            sys_rst_q <= 1'b1;
            edge_q    <= '0;
            timeout_q <= '0;
            under_q   <= '0;
            over_q    <= '0;
        end else begin
            state_q   <= state_d;
            sys_rst_q <= (state_d == StResetHold);
            edge_q    <= edge_d;
            timeout_q <= timeout_d;
            under_q   <= under_d;
            over_q    <= over_d;
        end
    end

    always_comb begin
        fifo_if.write_en = 1'b0;
        fifo_if.read_en  = 1'b0;
        if (!sys_rst_q) begin
            if (state_q == StPrefill || state_q == StStream) fifo_if.write_en = ~fifo_if.fifo_full;
            if (state_q == StStream) fifo_if.read_en = ~fifo_if.fifo_empty;
        end
    end

    always_comb begin
        led = LedReset;
        case (state_q)
            StWaitFrames: led = LedWait;
            StPrefill:    led = LedPrefill;
            StStream:     led = (under_q != '0 || over_q != '0) ? LedStreamErr : LedStream;
            default:      led = LedReset;
        endcase
    end

    assign fifo_if.sys_rst = sys_rst_q;
    assign {led_red, led_green, led_blue} = led;
    assign state_o      = state_q;
    assign underrun_cnt = under_q;
    assign overrun_cnt  = over_q;

endmodule
